// File: rtl/mux_nto1_reg.sv
// Registered N:1 operand multiplexer with fixed-select and round-robin grant modes.
// A single output register sits between the granted input channel and the downstream consumer.
module mux_nto1_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Handshakes: a word moves on any rising edge where valid and ready are both high.
  // A producer holds valid and data steady until that edge, and valid never waits on ready.
  // in_ready is combinational and goes only to the granted channel.
  // Because of that, in fixed-select mode it may be high while in_valid is low.

  logic              can_accept;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_next;
  logic [WIDTH-1:0]  grant_data;
  logic              grant_in_valid;
  logic              xfer;
  logic              found;
  int                idx;

  assign can_accept = !out_valid || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    found     = 1'b0;
    idx       = 0;
    if (!mode) begin
      if (int'(sel) < NUM_IN) begin
        grant_vld = 1'b1;
        grant     = sel;
      end
    end else begin
      // Scan from rr_ptr upward, wrapping modulo NUM_IN. The first valid channel wins.
      for (int k = 0; k < NUM_IN; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
          if (!found && i == idx && in_valid[i]) begin
            found     = 1'b1;
            grant_vld = 1'b1;
            grant     = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    in_ready       = '0;
    grant_data     = '0;
    grant_in_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_vld && int'(grant) == i) begin
        in_ready[i]    = can_accept;
        grant_data     = in_data[i*WIDTH +: WIDTH];
        grant_in_valid = in_valid[i];
      end
    end
  end

  assign xfer    = grant_vld && grant_in_valid && can_accept;
  assign rr_next = (int'(grant) == NUM_IN - 1) ? '0 : grant + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_data  <= grant_data;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode) rr_ptr <= rr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: fixed select, stall/refill, round-robin, invalid select, async reset.
// SEL_W is widened to 3 so that an out-of-range select (5) can be driven with four channels.
module tb_mux_nto1_reg;
  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;

  int tests_run = 0;
  int tests_failed = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_word;

  mux_nto1_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic [SEL_W-1:0] c);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_chan"},  32'(out_chan),  32'(c));
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    tick(); tick();
    check_out("reset", 1'b0, 8'h00, 3'd0);

    // 1: fixed select of channel 2
    rst_n = 1'b1;
    mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; in_data = {8'h00, 8'hA5, 8'h00, 8'h00}; out_ready = 1'b1;
    #1 check("t1_ready_pre", 32'(in_ready), 32'h4);
    tick();
    check_out("t1_out", 1'b1, 8'hA5, 3'd2);
    check("t1_ready_post", 32'(in_ready), 32'h4);
    in_valid = '0;
    tick();
    check_out("t1_drain", 1'b0, 8'hA5, 3'd2);

    // 2: stall then simultaneous drain and fill
    sel = 3'd1; out_ready = 1'b0; in_valid = 4'b0010; in_data = {8'h00, 8'h00, 8'h11, 8'h00};
    #1 check("t2_ready_empty", 32'(in_ready), 32'h2);
    tick();
    check_out("t2_cap", 1'b1, 8'h11, 3'd1);
    in_data = {8'h00, 8'h00, 8'h22, 8'h00};
    #1 check("t2_ready_stall", 32'(in_ready), 32'h0);
    tick();
    check_out("t2_hold", 1'b1, 8'h11, 3'd1);
    out_ready = 1'b1;
    #1 check("t2_ready_drain", 32'(in_ready), 32'h2);
    tick();
    check_out("t2_refill", 1'b1, 8'h22, 3'd1);
    in_valid = '0;
    tick();
    check("t2_empty", 32'(out_valid), 32'h0);

    // 3: round robin with all channels valid; data encodes the channel
    mode = 1'b1; in_valid = 4'b1111; in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'h13); exp_q.push_back(8'h10);
    for (int n = 0; n < 5; n++) begin
      tick();
      exp_word = exp_q.pop_front();
      check_out($sformatf("t3_rr%0d", n), 1'b1, exp_word, 3'(exp_word - 8'h10));
    end
    in_valid = '0;
    tick();
    check("t3_empty", 32'(out_valid), 32'h0);

    // 4: pointer is now 1; only channels 0 and 3 request
    in_valid = 4'b1001;
    #1 check("t4_ready_a", 32'(in_ready), 32'h8);
    tick();
    check_out("t4_a", 1'b1, 8'h13, 3'd3);
    check("t4_ready_b", 32'(in_ready), 32'h1);
    tick();
    check_out("t4_b", 1'b1, 8'h10, 3'd0);
    check("t4_ready_c", 32'(in_ready), 32'h8);
    in_valid = '0;
    tick();
    check("t4_empty", 32'(out_valid), 32'h0);

    // 5: out-of-range fixed select grants nothing
    mode = 1'b0; sel = 3'd5; in_valid = 4'b1111;
    for (int n = 0; n < 10; n++) begin
      tick();
      check($sformatf("t5_ready%0d", n), 32'(in_ready), 32'h0);
      check($sformatf("t5_valid%0d", n), 32'(out_valid), 32'h0);
    end

    // 6: asynchronous reset while holding a word
    sel = 3'd3; in_valid = 4'b1000; out_ready = 1'b0;
    tick();
    check_out("t6_load", 1'b1, 8'h13, 3'd3);
    in_valid = '0;
    #3 rst_n = 1'b0;
    #1 check_out("t6_async", 1'b0, 8'h00, 3'd0);
    in_valid = 4'b1000; out_ready = 1'b1;
    tick();
    check_out("t6_in_reset", 1'b0, 8'h00, 3'd0);
    rst_n = 1'b1;
    mode = 1'b1; in_valid = 4'b0110;
    #1 check("t6_ready_first", 32'(in_ready), 32'h2);
    tick();
    check_out("t6_first", 1'b1, 8'h11, 3'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
